// File: rtl/pipeline_ctrl_if.sv
// Pipeline spine bus: fetch input, stall/kill requests, per-slot state and retire port.
// Perf counter signals exist only when PIPE_PERF_CNT_EN is defined.
interface pipeline_ctrl_if #(
   parameter int NUM_STAGES = 5,
   parameter int DATA_W     = 64,
   parameter int KILL_W     = $clog2(NUM_STAGES)
`ifdef PIPE_PERF_CNT_EN
   ,
   parameter int CNT_W      = 32
`endif
);
   logic                           in_valid;
   logic [DATA_W-1:0]              in_data;
   logic                           in_ready;
   logic [NUM_STAGES-1:0]          stall_req;
   logic                           kill;
   logic [KILL_W-1:0]              kill_stage;
   logic [NUM_STAGES-1:0]          stage_valid;
   logic [NUM_STAGES*DATA_W-1:0]   stage_data;
   logic [NUM_STAGES-1:0]          stall_eff;
   logic                           out_valid;
   logic [DATA_W-1:0]              out_data;
`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0]               perf_stall_cycles;
   logic [CNT_W-1:0]               perf_kills;
   logic [CNT_W-1:0]               perf_retired;
`endif

   modport master (
      output in_valid, in_data, stall_req, kill, kill_stage,
      input  in_ready, stage_valid, stage_data, stall_eff, out_valid, out_data
`ifdef PIPE_PERF_CNT_EN
      ,
      input  perf_stall_cycles, perf_kills, perf_retired
`endif
   );

   modport slave (
      input  in_valid, in_data, stall_req, kill, kill_stage,
      output in_ready, stage_valid, stage_data, stall_eff, out_valid, out_data
`ifdef PIPE_PERF_CNT_EN
      ,
      output perf_stall_cycles, perf_kills, perf_retired
`endif
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// In-order pipeline spine: per-slot valid/payload with stall propagation, bubbles and kill.
// Define PIPE_PERF_CNT_EN to add stall/kill/retire performance counters.
module pipeline_ctrl #(
   parameter int NUM_STAGES = 5,
   parameter int DATA_W     = 64,
   parameter int KILL_W     = $clog2(NUM_STAGES)
`ifdef PIPE_PERF_CNT_EN
   ,
   parameter int CNT_W      = 32
`endif
) (
   input logic            clk,
   input logic            rst,
   pipeline_ctrl_if.slave bus
);
   logic [NUM_STAGES-1:0]             valid_q, valid_d;
   logic [NUM_STAGES-1:0][DATA_W-1:0] data_q, data_d;
   logic [NUM_STAGES-1:0][DATA_W-1:0] prev_d;
   logic [NUM_STAGES-1:0]             prev_v;
   logic [NUM_STAGES-1:0]             stall_eff;
   logic [NUM_STAGES-1:0]             prev_stall;
   logic                              acc;
   int                                kidx;
   logic                              retire;

   // A stall at stage i holds every younger (lower-index) stage.
   always_comb begin
      acc       = 1'b0;
      stall_eff = '0;
      for (int i = NUM_STAGES-1; i >= 0; i--) begin
         acc          = acc | bus.stall_req[i];
         stall_eff[i] = acc;
      end
   end

   always_comb begin
      kidx = int'(bus.kill_stage);
      if (kidx >= NUM_STAGES) kidx = NUM_STAGES-1;
   end

   always_comb begin
      prev_v     = {valid_q[NUM_STAGES-2:0], bus.in_valid};
      prev_d     = {data_q[NUM_STAGES-2:0], bus.in_data};
      prev_stall = {stall_eff[NUM_STAGES-2:0], 1'b0};
      valid_d    = valid_q;
      data_d     = data_q;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (bus.kill && i < kidx) begin
            valid_d[i] = 1'b0;
         end else if (bus.kill && i == kidx && !stall_eff[i]) begin
            valid_d[i] = 1'b0;
         end else if (!stall_eff[i]) begin
            if (prev_stall[i]) begin
               valid_d[i] = 1'b0;
            end else begin
               valid_d[i] = prev_v[i];
               data_d[i]  = prev_d[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign retire          = valid_q[NUM_STAGES-1] & ~stall_eff[NUM_STAGES-1];
   assign bus.in_ready    = ~stall_eff[0];
   assign bus.stall_eff   = stall_eff;
   assign bus.stage_valid = valid_q;
   assign bus.stage_data  = data_q;
   assign bus.out_valid   = valid_q[NUM_STAGES-1];
   assign bus.out_data    = data_q[NUM_STAGES-1];

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, kill_cnt_q, ret_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         kill_cnt_q  <= '0;
         ret_cnt_q   <= '0;
      end else begin
         if (stall_eff[0])              stall_cnt_q <= stall_cnt_q + 1'b1;
         if (bus.kill && valid_q[kidx]) kill_cnt_q  <= kill_cnt_q + 1'b1;
         if (retire)                    ret_cnt_q   <= ret_cnt_q + 1'b1;
      end
   end

   assign bus.perf_stall_cycles = stall_cnt_q;
   assign bus.perf_kills        = kill_cnt_q;
   assign bus.perf_retired      = ret_cnt_q;
`else
   logic unused_retire;
   assign unused_retire = retire;
`endif
endmodule
